noc_input_unit: RTL and testbench
=================================

NOC_INPUT_UNIT -- requirements
Module: noc_input_unit

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of virtual channels (>=1).
REQ-002 SHALL have parameter FLIT_W, default 64, flit width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, flit buffer depth per VC (power of two, >=2).
REQ-004 SHALL have parameter COORD_W, default 3, width of one mesh coordinate.
REQ-005 SHALL have parameters LOCAL_X and LOCAL_Y, default 0, this router's coordinates.
REQ-006 SHALL have ports (VW = max(1,$clog2(CHANNELS))):
  noc_clk  in  1  sole clock, rising edge
  noc_rst_n  in  1  asynchronous active-low reset
  i_flit_valid  in  1  incoming flit strobe
  i_flit_vc  in  VW  target VC of incoming flit
  i_flit_data  in  FLIT_W  incoming flit
  o_credit  out  CHANNELS  one-cycle credit return pulse per VC
  o_request  out  [5][CHANNELS]  VC i has a flit ready for output port j
  o_start_of_packet  out  [5][CHANNELS]  VC i holds a packet routed to port j
  o_end_of_packet  out  [5][CHANNELS]  tail of VC i leaves toward port j
  o_free  out  [5][CHANNELS]  VC i released at port j
  i_grant  in  [5][CHANNELS]  output port j accepts front flit of VC i
  o_flit_data  out  [CHANNELS][FLIT_W]  front flit of each VC
  o_overflow  out  CHANNELS  sticky: flit dropped on full VC
  o_proto_err  out  CHANNELS  sticky: body/tail arrived with no open packet
REQ-007 Port index SHALL be 0 local, 1 east, 2 west, 3 north, 4 south.

Function
REQ-008 Flit type SHALL be i_flit_data[FLIT_W-1:FLIT_W-2]: 00 body, 01 head, 10 tail, 11 single (head+tail).
REQ-009 Head/single destination SHALL be X = data[COORD_W-1:0], Y = data[2*COORD_W-1:COORD_W].
REQ-010 Route SHALL be XY: X>LOCAL_X east; X<LOCAL_X west; else Y>LOCAL_Y north; Y<LOCAL_Y south; else local (unsigned compare).
REQ-011 Each VC SHALL own a DEPTH-entry FIFO with a 0..DEPTH occupancy counter.
REQ-012 Push SHALL occur when i_flit_valid and VC not full, or full and that VC pops in the same cycle; otherwise flit dropped and o_overflow[vc] set.
REQ-013 A pushed flit SHALL be at the FIFO front, and on o_flit_data, the cycle after the push edge.
REQ-014 Each VC SHALL run FSM IDLE/ACTIVE, with route register of 3 bits.
REQ-015 IDLE, front head/single: route latched from front, go ACTIVE next edge; no pop in IDLE.
REQ-016 IDLE, front body/tail: flit discarded (popped, credit returned), o_proto_err[vc] set, stay IDLE.
REQ-017 ACTIVE: o_start_of_packet[route][i]=1 continuously; o_request[route][i]=FIFO non-empty.
REQ-018 Pop SHALL occur when o_request[route][i] & i_grant[route][i]; grants on other ports ignored.
REQ-019 Pop of tail/single SHALL assert o_end_of_packet and o_free [route][i] that cycle (combinational) and go IDLE next edge.
REQ-020 Head-to-request latency SHALL be 2 cycles from push edge (front N+1, ACTIVE N+2); sustained 1 flit/cycle per VC.
REQ-021 o_credit[i] SHALL be a registered pulse the cycle after every pop, including REQ-016 discards; dropped pushes give no credit.
REQ-022 All o_request/o_start_of_packet/o_end_of_packet/o_free bits for ports other than route, or any port in IDLE, SHALL be 0.
REQ-023 VCs SHALL be fully independent; simultaneous push to one VC and pop of another allowed.
REQ-024 Pointers SHALL wrap modulo DEPTH; empty FIFO never pops, full FIFO never overwrites.

Reset
REQ-025 noc_rst_n low SHALL asynchronously empty all FIFOs, set FSMs IDLE, route 0, clear o_credit, o_overflow, o_proto_err; all request/sop/eop/free outputs 0.
REQ-026 Reset mid-packet SHALL discard buffered flits without credits; first flit after release must be head.
REQ-027 o_flit_data content SHALL be don't-care while FIFO empty.

Verification
REQ-028 LOCAL=(1,1), single flit dest (3,1) on VC0 at edge N -> o_request[1][0]=1 at N+2; grant -> o_end_of_packet[1][0]=o_free[1][0]=1 same cycle, o_credit[0]=1 next cycle.
REQ-029 Head(dest 1,0)+2 body+tail on VC1, grant held -> port 4 request 4 consecutive cycles, sop held throughout, eop only with tail, 4 credit pulses.
REQ-030 5 flits to VC0 (DEPTH=4), no grant -> 5th dropped, o_overflow[0]=1, occupancy 4, 4 credits after drain.
REQ-031 Body flit as first VC0 flit -> discarded, o_proto_err[0]=1, one credit, no request.
REQ-032 Packets on VC0 (east) and VC1 (local) interleaved, grants on both -> independent streams, no cross-VC corruption.
REQ-033 Reset asserted after head popped, body pending -> all outputs 0 immediately; new head after release routes normally.

Source files
------------

// File: rtl/noc_input_unit.sv
// NoC router input unit: per-VC flit FIFOs, XY route computation and a
// per-VC packet FSM that requests the routed output port and returns credits.
module noc_input_unit #(
  parameter int CHANNELS = 2,
  parameter int FLIT_W   = 64,
  parameter int DEPTH    = 4,
  parameter int COORD_W  = 3,
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0,
  localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            noc_clk,
  input  logic                            noc_rst_n,
  input  logic                            i_flit_valid,
  input  logic [VW-1:0]                   i_flit_vc,
  input  logic [FLIT_W-1:0]               i_flit_data,
  output logic [CHANNELS-1:0]             o_credit,
  output logic [4:0][CHANNELS-1:0]        o_request,
  output logic [4:0][CHANNELS-1:0]        o_start_of_packet,
  output logic [4:0][CHANNELS-1:0]        o_end_of_packet,
  output logic [4:0][CHANNELS-1:0]        o_free,
  input  logic [4:0][CHANNELS-1:0]        i_grant,
  output logic [CHANNELS-1:0][FLIT_W-1:0] o_flit_data,
  output logic [CHANNELS-1:0]             o_overflow,
  output logic [CHANNELS-1:0]             o_proto_err
);

  // state    | meaning
  // S_IDLE   | no open packet; front head/single latches route, front body/tail is discarded
  // S_ACTIVE | packet open on r_route; front flits requested, popping tail/single closes it
  typedef enum logic {S_IDLE, S_ACTIVE} vc_state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  logic [FLIT_W-1:0]           r_mem [CHANNELS][DEPTH];
  logic [CHANNELS-1:0][AW-1:0] r_rd_ptr;
  logic [CHANNELS-1:0][AW-1:0] r_wr_ptr;
  logic [CHANNELS-1:0][AW:0]   r_count;
  vc_state_t                   r_state [CHANNELS];
  logic [CHANNELS-1:0][2:0]    r_route;

  logic [CHANNELS-1:0][FLIT_W-1:0] w_front;
  logic [CHANNELS-1:0][1:0]        w_type;
  logic [CHANNELS-1:0][2:0]        w_front_route;
  logic [CHANNELS-1:0]             w_empty, w_full, w_discard, w_take, w_last;
  logic [CHANNELS-1:0]             w_pop, w_push, w_drop;

  function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] flit);
    logic [COORD_W-1:0] x, y;
    x = flit[COORD_W-1:0];
    y = flit[2*COORD_W-1:COORD_W];
    if (x > LX)      return 3'd1;
    else if (x < LX) return 3'd2;
    else if (y > LY) return 3'd3;
    else if (y < LY) return 3'd4;
    else             return 3'd0;
  endfunction

  // Type bit 0 marks a head (head/single), bit 1 marks a tail (tail/single).
  always_comb begin
    o_request         = '0;
    o_start_of_packet = '0;
    o_end_of_packet   = '0;
    o_free            = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_front[c]       = r_mem[c][r_rd_ptr[c]];
      o_flit_data[c]   = w_front[c];
      w_type[c]        = w_front[c][FLIT_W-1 -: 2];
      w_front_route[c] = xy_route(w_front[c]);
      w_empty[c]       = (r_count[c] == '0);
      w_full[c]        = (r_count[c] == FULL_CNT);
      w_discard[c]     = (r_state[c] == S_IDLE) && !w_empty[c] && !w_type[c][0];
      w_take[c]        = (r_state[c] == S_ACTIVE) && !w_empty[c] && i_grant[r_route[c]][c];
      w_last[c]        = w_take[c] && w_type[c][1];
      w_pop[c]         = w_discard[c] || w_take[c];
      w_push[c]        = i_flit_valid && (i_flit_vc == VW'(c)) && (!w_full[c] || w_pop[c]);
      w_drop[c]        = i_flit_valid && (i_flit_vc == VW'(c)) && !w_push[c];
      if (r_state[c] == S_ACTIVE) begin
        o_start_of_packet[r_route[c]][c] = 1'b1;
        o_request[r_route[c]][c]         = !w_empty[c];
        o_end_of_packet[r_route[c]][c]   = w_last[c];
        o_free[r_route[c]][c]            = w_last[c];
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= i_flit_data;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) r_state[c] <= S_IDLE;
      r_route     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      o_credit    <= '0;
      o_overflow  <= '0;
      o_proto_err <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        o_credit[c] <= w_pop[c];
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + AW'(1);
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + AW'(1);
        r_count[c] <= r_count[c] + (AW+1)'(w_push[c]) - (AW+1)'(w_pop[c]);
        if (w_drop[c])    o_overflow[c]  <= 1'b1;
        if (w_discard[c]) o_proto_err[c] <= 1'b1;
        case (r_state[c])
          S_IDLE: begin
            if (!w_empty[c] && w_type[c][0]) begin
              r_state[c] <= S_ACTIVE;
              r_route[c] <= w_front_route[c];
            end
          end
          S_ACTIVE: begin
            if (w_last[c]) r_state[c] <= S_IDLE;
          end
          default: r_state[c] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// Bench for noc_input_unit: directed scenarios, then credit-respecting random
// traffic checked by a per-VC scoreboard fed from a packet-level model.
module tb_noc_input_unit;
  localparam int CH = 2, FW = 16, DEPTH = 4, LX = 1, LY = 1;

  logic                clk = 0;
  logic                rst_n;
  logic                i_flit_valid;
  logic [0:0]          i_flit_vc;
  logic [FW-1:0]       i_flit_data;
  logic [CH-1:0]       o_credit;
  logic [4:0][CH-1:0]  o_request, o_start_of_packet, o_end_of_packet, o_free, i_grant;
  logic [CH-1:0][FW-1:0] o_flit_data;
  logic [CH-1:0]       o_overflow, o_proto_err;

  noc_input_unit #(.CHANNELS(CH), .FLIT_W(FW), .DEPTH(DEPTH), .COORD_W(3),
                   .LOCAL_X(LX), .LOCAL_Y(LY)) dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .i_flit_valid(i_flit_valid), .i_flit_vc(i_flit_vc),
    .i_flit_data(i_flit_data), .o_credit(o_credit), .o_request(o_request),
    .o_start_of_packet(o_start_of_packet), .o_end_of_packet(o_end_of_packet),
    .o_free(o_free), .i_grant(i_grant), .o_flit_data(o_flit_data),
    .o_overflow(o_overflow), .o_proto_err(o_proto_err));

  always #5 clk = ~clk;

  typedef struct { int port; logic [FW-1:0] data; bit last; } exp_t;
  exp_t exp_q [2][$];

  int vectors = 0, miscompares = 0;
  int cred_cnt [2] = '{0, 0};
  int cred_base [2], sent [2];
  bit open_pkt [2];
  int rem [2], cur_port [2];
  logic [CH-1:0] exp_proto;
  bit mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int ref_route(input int x, input int y);
    if (x > LX) return 1;
    if (x < LX) return 2;
    if (y > LY) return 3;
    if (y < LY) return 4;
    return 0;
  endfunction

  function automatic int outstanding(input int c);
    return sent[c] - (cred_cnt[c] - cred_base[c]);
  endfunction

  // Next flit of VC c's stream; expectations recorded as it is issued.
  task automatic gen_send(input int c);
    logic [FW-1:0] d;
    exp_t e;
    int x, y;
    d = FW'($urandom);
    if (!open_pkt[c]) begin
      if ($urandom_range(0, 15) == 0) begin
        d[15:14] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10;
        exp_proto[c] = 1'b1;
      end else begin
        x = $urandom_range(0, 3);
        y = $urandom_range(0, 3);
        d[2:0] = 3'(x);
        d[5:3] = 3'(y);
        cur_port[c] = ref_route(x, y);
        if ($urandom_range(0, 2) == 0) begin
          d[15:14] = 2'b11;
          e = '{cur_port[c], d, 1'b1};
        end else begin
          d[15:14] = 2'b01;
          open_pkt[c] = 1;
          rem[c] = $urandom_range(0, 3);
          e = '{cur_port[c], d, 1'b0};
        end
        exp_q[c].push_back(e);
      end
    end else if (rem[c] > 0) begin
      d[15:14] = 2'b00;
      rem[c]--;
      exp_q[c].push_back('{cur_port[c], d, 1'b0});
    end else begin
      d[15:14] = 2'b10;
      open_pkt[c] = 0;
      exp_q[c].push_back('{cur_port[c], d, 1'b1});
    end
    i_flit_valid = 1;
    i_flit_vc    = 1'(c);
    i_flit_data  = d;
    sent[c]++;
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) if (o_credit[c]) cred_cnt[c]++;
  end

  always @(negedge clk) begin
    exp_t e;
    int nreq;
    if (mon_en) begin
      for (int c = 0; c < CH; c++) begin
        nreq = 0;
        for (int p = 0; p < 5; p++) if (o_request[p][c]) nreq++;
        check("req_onehot", 64'(nreq <= 1), 64'd1);
        for (int p = 0; p < 5; p++) begin
          if (o_request[p][c] && i_grant[p][c]) begin
            if (exp_q[c].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_pop vc%0d port%0d: got %0h expected none", c, p, o_flit_data[c]);
            end else begin
              e = exp_q[c].pop_front();
              check("pop_port", 64'(p), 64'(e.port));
              check("pop_data", 64'(o_flit_data[c]), 64'(e.data));
              check("pop_eop", 64'(o_end_of_packet[p][c]), 64'(e.last));
              check("pop_free", 64'(o_free[p][c]), 64'(e.last));
              check("pop_sop", 64'(o_start_of_packet[p][c]), 64'd1);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] ov [5];
    logic [FW-1:0] tail_data;
    int c0, pops, found, done;
    ov = '{16'h4009, 16'h0AAA, 16'h1555, 16'h8F0F, 16'hC001};
    rst_n = 0; i_flit_valid = 0; i_flit_vc = 0; i_flit_data = '0; i_grant = '0;
    exp_proto = '0;
    repeat (2) @(negedge clk);
    check("rst_request", 64'(o_request), 64'd0);
    check("rst_credit", 64'(o_credit), 64'd0);
    check("rst_flags", 64'({o_overflow, o_proto_err}), 64'd0);
    @(negedge clk); rst_n = 1;
    tick();

    // single flit to (3,1): east after two cycles
    i_flit_valid = 1; i_flit_vc = 0; i_flit_data = 16'hC00B;
    tick(); i_flit_valid = 0;
    @(negedge clk);
    check("t1_req_idle", 64'(o_request), 64'd0);
    check("t1_front", 64'(o_flit_data[0]), 64'hC00B);
    tick(); i_grant[1][0] = 1;
    @(negedge clk);
    check("t1_req", 64'(o_request), 64'h004);
    check("t1_sop", 64'(o_start_of_packet), 64'h004);
    check("t1_eop", 64'(o_end_of_packet), 64'h004);
    check("t1_free", 64'(o_free), 64'h004);
    tick(); i_grant = '0;
    @(negedge clk);
    check("t1_credit", 64'(o_credit), 64'h1);
    check("t1_req_after", 64'(o_request), 64'd0);

    // stray body first on VC0
    tick(); i_flit_valid = 1; i_flit_vc = 0; i_flit_data = 16'h0123;
    tick(); i_flit_valid = 0; c0 = cred_cnt[0];
    @(negedge clk);
    check("t3_req", 64'(o_request), 64'd0);
    tick();
    @(negedge clk);
    check("t3_credit", 64'(o_credit), 64'h1);
    check("t3_proto", 64'(o_proto_err), 64'h1);
    tick(); tick();
    check("t3_credits", 64'(cred_cnt[0] - c0), 64'd1);
    check("t3_req_after", 64'(o_request), 64'd0);

    // overflow: 5 flits into a 4-deep VC without grants
    for (int i = 0; i < 5; i++) begin
      i_flit_valid = 1; i_flit_vc = 0; i_flit_data = ov[i];
      tick();
    end
    i_flit_valid = 0;
    @(negedge clk);
    check("t2_overflow", 64'(o_overflow), 64'h1);
    check("t2_req", 64'(o_request), 64'h001);
    tick(); c0 = cred_cnt[0]; i_grant[0][0] = 1;
    pops = 0; tail_data = '0;
    repeat (12) begin
      @(negedge clk);
      if (o_request[0][0] && i_grant[0][0]) pops++;
      if (o_end_of_packet[0][0]) tail_data = o_flit_data[0];
    end
    tick(); i_grant = '0;
    check("t2_pops", 64'(pops), 64'd4);
    check("t2_tail", 64'(tail_data), 64'h8F0F);
    check("t2_credits", 64'(cred_cnt[0] - c0), 64'd4);
    check("t2_req_after", 64'(o_request), 64'd0);

    // reset with a body pending on VC1
    i_grant[4][1] = 1; i_flit_valid = 1; i_flit_vc = 1; i_flit_data = 16'h4001;
    tick(); i_flit_data = 16'h0BEE;
    tick(); i_flit_valid = 0;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      @(negedge clk);
      if (o_request[4][1]) found = 1;
    end
    check("t4_head_req", 64'(found), 64'd1);
    tick(); i_grant = '0;
    @(negedge clk);
    check("t4_body_pending", 64'(o_request), 64'h200);
    #2 rst_n = 0;
    #1;
    check("t4_rst_req", 64'(o_request), 64'd0);
    check("t4_rst_sop", 64'(o_start_of_packet), 64'd0);
    check("t4_rst_eopfree", 64'({o_end_of_packet, o_free}), 64'd0);
    check("t4_rst_flags", 64'({o_credit, o_overflow, o_proto_err}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick(); i_flit_valid = 1; i_flit_vc = 1; i_flit_data = 16'hC009;
    tick(); i_flit_valid = 0;
    @(negedge clk);
    check("t4_front", 64'(o_flit_data[1]), 64'hC009);
    check("t4_req_idle", 64'(o_request), 64'd0);
    tick(); i_grant[0][1] = 1;
    @(negedge clk);
    check("t4_req", 64'(o_request), 64'h002);
    check("t4_eop", 64'(o_end_of_packet), 64'h002);
    tick(); i_grant = '0;
    @(negedge clk);
    check("t4_credit", 64'(o_credit), 64'h2);
    tick();

    // random credit-respecting traffic on both VCs
    for (int c = 0; c < CH; c++) begin
      cred_base[c] = cred_cnt[c]; sent[c] = 0; open_pkt[c] = 0; rem[c] = 0;
    end
    exp_proto = '0;
    mon_en = 1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      i_grant = 10'($urandom);
      i_flit_valid = 0;
      if ($urandom_range(0, 3) != 0) begin
        int c;
        c = $urandom_range(0, 1);
        if (outstanding(c) < DEPTH) gen_send(c);
      end
    end
    // finish open packets so every VC can drain
    for (int c = 0; c < CH; c++) begin
      while (open_pkt[c]) begin
        tick();
        i_grant = '1;
        i_flit_valid = 0;
        if (outstanding(c) < DEPTH) gen_send(c);
      end
    end
    tick(); i_flit_valid = 0; i_grant = '1;
    done = 0;
    for (int k = 0; k < 300 && done == 0; k++) begin
      tick();
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          outstanding(0) == 0 && outstanding(1) == 0) done = 1;
    end
    repeat (3) tick();
    mon_en = 0;
    check("rnd_q0_empty", 64'(exp_q[0].size()), 64'd0);
    check("rnd_q1_empty", 64'(exp_q[1].size()), 64'd0);
    check("rnd_credits0", 64'(outstanding(0)), 64'd0);
    check("rnd_credits1", 64'(outstanding(1)), 64'd0);
    check("rnd_proto", 64'(o_proto_err), 64'(exp_proto));
    check("rnd_overflow", 64'(o_overflow), 64'd0);
    check("rnd_req_idle", 64'(o_request), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
